// File: rtl/ws_bit_decoder.sv
// ws_bit_decoder: times WS high pulses/low gaps into shift commands {decode_bit, shift_en, treset}; o_err port when WS_BIT_DECODER_ERR_EN is defined
module ws_bit_decoder #(
  parameter int CNT_W        = 10,
  parameter int MIN_HIGH     = 3,
  parameter int BIT_THRESH   = 12,
  parameter int RESET_CYCLES = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_ctrl,
  output logic [2:0]       o_shift,
`ifdef WS_BIT_DECODER_ERR_EN
  output logic             o_err,
`endif
  output logic [CNT_W-1:0] o_count
);
  if (!(MIN_HIGH < BIT_THRESH && BIT_THRESH < RESET_CYCLES && RESET_CYCLES < 2**CNT_W)) begin : g_bad_params
    $error("ws_bit_decoder: need MIN_HIGH < BIT_THRESH < RESET_CYCLES < 2**CNT_W");
  end
  localparam logic [CNT_W-1:0] C_MAX = '1;
  localparam logic [CNT_W-1:0] C_MIN = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] C_BIT = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] C_RST = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             dbit, dbit_n, sen, sen_n, tres, tres_n, rise, fall;
`ifdef WS_BIT_DECODER_ERR_EN
  logic             err, err_n;
`endif
  always_comb begin
    rise    = i_ctrl[1] & ~i_ctrl[0];
    fall    = i_ctrl[0] & ~i_ctrl[1];
    cnt_inc = (cnt == C_MAX) ? cnt : cnt + C_ONE;
    state_n = state;
    cnt_n   = cnt;
    dbit_n  = dbit;
    sen_n   = 1'b0;
    tres_n  = 1'b0;
`ifdef WS_BIT_DECODER_ERR_EN
    err_n   = 1'b0;
`endif
    case (state)
      IDLE: begin
        state_n = rise ? HIGH : IDLE;
        cnt_n   = rise ? C_ONE : '0;
      end
      HIGH: begin
        state_n = fall ? LOW : HIGH;
        cnt_n   = fall ? C_ONE : cnt_inc;
        sen_n   = fall && cnt >= C_MIN;
        dbit_n  = (fall && cnt >= C_MIN) ? (cnt >= C_BIT) : dbit;
`ifdef WS_BIT_DECODER_ERR_EN
        err_n   = fall && (cnt < C_MIN || cnt == C_MAX);
`endif
      end
      LOW: begin
        tres_n  = !rise && cnt == C_RST;
        state_n = rise ? HIGH : (cnt == C_RST) ? IDLE : LOW;
        cnt_n   = rise ? C_ONE : (cnt == C_RST) ? '0 : cnt_inc;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dbit  <= 1'b0;
      sen   <= 1'b0;
      tres  <= 1'b0;
`ifdef WS_BIT_DECODER_ERR_EN
      err   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dbit  <= dbit_n;
      sen   <= sen_n;
      tres  <= tres_n;
`ifdef WS_BIT_DECODER_ERR_EN
      err   <= err_n;
`endif
    end
  end
  assign o_shift = {dbit, sen, tres};
  assign o_count = cnt;
`ifdef WS_BIT_DECODER_ERR_EN
  assign o_err   = err;
`endif
endmodule

// File: tb/tb_ws_bit_decoder.sv
// tb_ws_bit_decoder: directed and random pulse trains checked against a pulse/gap-level reference model
module tb_ws_bit_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ctrl = 2'b00;
  logic [2:0] shift;
  logic [9:0] count;
  logic       exp_bit = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
`ifdef WS_BIT_DECODER_ERR_EN
  logic       err;
`endif
  ws_bit_decoder dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_ctrl  (ctrl),
    .o_shift (shift),
`ifdef WS_BIT_DECODER_ERR_EN
    .o_err   (err),
`endif
    .o_count (count)
  );
  always #5 clk = ~clk;
  task automatic step(input logic [1:0] c);
    @(negedge clk);
    ctrl = c;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [2:0] es, input int ec, input logic ee);
    n_cmp++;
    assert (shift === es) else begin
      n_bad++;
      $error("FAIL %s o_shift got %b expected %b", tag, shift, es);
    end
    n_cmp++;
    assert (count === 10'(ec)) else begin
      n_bad++;
      $error("FAIL %s o_count got %0d expected %0d", tag, count, ec);
    end
`ifdef WS_BIT_DECODER_ERR_EN
    n_cmp++;
    assert (err === ee) else begin
      n_bad++;
      $error("FAIL %s o_err got %b expected %b", tag, err, ee);
    end
`endif
  endtask
  // high of w cycles (rising sampled w cycles before falling), then gap idle cycles;
  // step g of the high phase carries a simultaneous-edge glitch (0 = none)
  task automatic pulse(input int w, input int gap, input int g);
    logic runt;
    int   lo;
    step(2'b10);
    chk("rise", {exp_bit, 2'b00}, 1, 1'b0);
    for (int i = 1; i < w; i++) begin
      step(i == g ? 2'b11 : 2'b00);
      chk("high", {exp_bit, 2'b00}, (i + 1 > 1023) ? 1023 : i + 1, 1'b0);
    end
    runt = w < 3;
    if (!runt) exp_bit = w >= 12;
    step(2'b01);
    chk("fall", {exp_bit, !runt, 1'b0}, 1, runt || w >= 1023);
    for (int i = 1; i <= gap; i++) begin
      step(2'b00);
      lo = i + 1;
      chk("low", {exp_bit, 1'b0, lo == 1001}, (lo <= 1000) ? lo : 0, 1'b0);
    end
  endtask
  initial begin
    #1;
    chk("async_reset", 3'b000, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b01);
    chk("idle_fall", 3'b000, 0, 1'b0);
    pulse(8, 5, 0);
    pulse(16, 5, 0);
    pulse(11, 4, 0);
    pulse(12, 4, 0);
    pulse(2, 4, 0);
    pulse(3, 4, 0);
    pulse(1, 3, 0);
    pulse(14, 5, 5);
    pulse(8, 1003, 0);
    pulse(16, 998, 0);
    pulse(9, 999, 0);
    pulse(13, 2, 0);
    pulse(1100, 3, 0);
    pulse(5, 2, 0);
    for (int k = 0; k < 30; k++)
      pulse($urandom_range(1, 24), ($urandom_range(0, 9) == 0) ? $urandom_range(997, 1004) : $urandom_range(1, 30), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
    step(2'b10);
    chk("rst_rise", {exp_bit, 2'b00}, 1, 1'b0);
    for (int i = 1; i < 7; i++) begin
      step(2'b00);
      chk("rst_high", {exp_bit, 2'b00}, i + 1, 1'b0);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_bit = 1'b0;
    chk("midpulse_reset", 3'b000, 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b01);
    chk("post_reset_fall", 3'b000, 0, 1'b0);
    pulse(16, 3, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ws_bit_decoder.md
Name: ws_bit_decoder

Overview:
- Pulse-width decoder stage of the LED serial receive pipeline.
- Consumes single-cycle rising/falling edge flags (control_path_t) from the upstream edge detector.
- Times each high pulse and low gap with a saturating 10-bit counter (decoder_input_t).
- Emits the shift_reg_input_t command (decode_bit, shift_en, treset) that drives the downstream shift register.

Parameters:
- CNT_W, 10: counter width; matches decoder_input_t.counter.
- MIN_HIGH, 3: high pulses shorter than this (cycles) are runts and are discarded.
- BIT_THRESH, 12: high width >= BIT_THRESH decodes as 1, otherwise 0. At 20 MHz: T0H=8, T1H=16.
- RESET_CYCLES, 1000: low gap length that signals latch/reset (50 us at 20 MHz). Elaboration error unless MIN_HIGH < BIT_THRESH < RESET_CYCLES < 2**CNT_W.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_ctrl  in  2  control_path_t {rising, falling}; one-cycle pulses, synchronous to i_clk
- o_shift  out  3  shift_reg_input_t {decode_bit, shift_en, treset}; registered
- o_count  out  10  decoder_input_t; live counter value, for debug/observation

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, cnt=0, o_shift=RESET_VALUES_SHIFT_REG (all 0), o_count=0.
  - Effect is immediate; release is synchronous to i_clk.
  - Reset mid-pulse discards the partial bit; no shift_en or treset is emitted for it.
- States: IDLE, HIGH, LOW.
- IDLE:
  - Waits for rising; falling is ignored; cnt holds 0.
  - On rising: cnt<=1, state<=HIGH.
- HIGH:
  - Each cycle without falling: cnt<=min(cnt+1, 2**CNT_W-1), saturating with no wrap.
  - On falling, evaluate the current cnt, which equals the high width W in cycles:
    - W < MIN_HIGH: runt; no shift_en; decode_bit unchanged.
    - Otherwise: shift_en<=1 for exactly one cycle; decode_bit<=(W >= BIT_THRESH).
    - In both cases: cnt<=1, state<=LOW.
  - A saturated (over-long) high decodes as 1.
  - rising while in HIGH is ignored.
- LOW:
  - Each cycle without rising: cnt<=saturating cnt+1.
  - When cnt==RESET_CYCLES and no rising that cycle: treset<=1 for exactly one cycle, cnt<=0, state<=IDLE.
  - On rising: cnt<=1, state<=HIGH; no treset.
  - rising in the same cycle as the threshold: rising wins, treset suppressed.
- Simultaneous rising & falling in one cycle: glitch. Both ignored; state and cnt advance as if neither were present.
- Latency: shift_en is high the cycle after falling is sampled. treset is high the cycle after the threshold cycle.
- shift_en and treset are never asserted together.
- decode_bit holds its last value between shift_en pulses.
- o_count mirrors cnt every cycle.

Optional Feature:
- Macro: WS_BIT_DECODER_ERR_EN.
- Defined:
  - Adds output port o_err (1 bit, registered, reset 0).
  - o_err pulses for one cycle, aligned with where shift_en would be, for a runt.
  - o_err also pulses, aligned with shift_en, when a high pulse reached saturation (2**CNT_W-1). The saturated bit is still shifted as 1.
- Not defined: no o_err port; runts are dropped silently; all other behaviour is identical.

Test Plan:
- Reset: i_rst_n=0 asynchronously mid-HIGH with cnt=7 -> o_shift=3'b000, o_count=0 immediately. After release, the next falling produces no shift_en.
- Bit decode: rising then falling 8 cycles later -> shift_en=1, decode_bit=0 one cycle after falling. Same with 16 cycles -> decode_bit=1. Boundary widths 11 -> 0, 12 -> 1.
- Runt: high width 2 -> no shift_en. With WS_BIT_DECODER_ERR_EN: o_err=1 for one cycle. Width 3 -> shift_en=1, decode_bit=0.
- Latch reset: after a valid bit, hold low with no rising -> treset=1 exactly one cycle when cnt reaches 1000, state=IDLE, o_count=0. Rising at cnt=999 -> no treset, new bit decoded normally.
- Simultaneous edges: in HIGH at cnt=5, i_ctrl=2'b11 -> ignored, cnt=6. A later falling at W=14 -> decode_bit=1.
- Saturation: hold high 1100 cycles -> o_count stops at 1023. falling -> shift_en=1, decode_bit=1; o_err=1 when the macro is defined.
